// File: rtl/mapper_ctx_seq_pkg.sv
// Shared encodings for the mapper context save/restore sequencer.
package mapper_ctx_seq_pkg;

   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StSave    = 3'd1,
      StRstWait = 3'd2,
      StRestore = 3'd3,
      StFin     = 3'd4
   } state_e;

   // Mapper register selects; slots store bytes at the same index.
   localparam logic [1:0] SelA = 2'd3;
   localparam logic [1:0] SelX = 2'd2;
   localparam logic [1:0] SelY = 2'd1;
   localparam logic [1:0] SelZ = 2'd0;

endpackage

// File: rtl/mapper_ctx_lifo.sv
// Context slot storage: DEPTH slots of 4 bytes, byte write port, async read port.
module mapper_ctx_lifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PW    = 2
) (
   input  logic          clk_i,
   input  logic          we_i,
   input  logic [PW-1:0] wr_slot_i,
   input  logic [1:0]    wr_byte_i,
   input  logic [7:0]    wr_data_i,
   input  logic [PW-1:0] rd_slot_i,
   input  logic [1:0]    rd_byte_i,
   output logic [7:0]    rd_data_o
);

   logic [7:0] mem_q [DEPTH][4];

   // Byte write; contents are intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[wr_slot_i][wr_byte_i] <= wr_data_i;
      end
   end

   assign rd_data_o = mem_q[rd_slot_i][rd_byte_i];

endmodule

// File: rtl/mapper_ctx_seq.sv
// Saves/restores the mapper A/X/Y/Z context around hypervisor entry/exit using a LIFO.
module mapper_ctx_seq
   import mapper_ctx_seq_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned PW    = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        ready_i,
   input  logic        save_req_i,
   input  logic        restore_req_i,
   input  logic        map_idle_i,
   input  logic [7:0]  map_reg_data_i,
   output logic        rd_override_o,
   output logic [1:0]  rd_sel_o,
   output logic        load_user_reg_o,
   output logic [1:0]  wr_sel_o,
   output logic [7:0]  wr_data_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [PW:0] depth_o
);

   localparam logic [PW:0] SpMax = (PW+1)'(DEPTH);
   localparam logic [PW:0] SpOne = (PW+1)'(1);

   state_e      state_q, state_d;
   logic [PW:0] sp_q, sp_d;
   logic [1:0]  step_q, step_d;
   logic        err_q, err_d;
   // Done pulse for rejected requests, raised while the FSM stays idle.
   logic        err_done_q, err_done_d;
   logic        lifo_we;
   logic [7:0]  lifo_rd;
   logic        sp_full, sp_empty;

   assign sp_full  = (sp_q == SpMax);
   assign sp_empty = (sp_q == '0);

   // State and datapath registers.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q    <= StIdle;
         sp_q       <= '0;
         step_q     <= SelA;
         err_q      <= 1'b0;
         err_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         step_q     <= step_d;
         err_q      <= err_d;
         err_done_q <= err_done_d;
      end
   end

   // Next-state: request arbitration, step sequencing and stack pointer updates.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      step_d     = step_q;
      err_d      = err_q;
      err_done_d = 1'b0;
      lifo_we    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (save_req_i) begin
               if (sp_full) begin
                  err_d      = 1'b1;
                  err_done_d = 1'b1;
               end else begin
                  state_d = StSave;
                  step_d  = SelA;
               end
            end else if (restore_req_i) begin
               if (sp_empty) begin
                  err_d      = 1'b1;
                  err_done_d = 1'b1;
               end else begin
                  state_d = StRstWait;
                  step_d  = SelA;
               end
            end
         end
         StSave: begin
            if (ready_i) begin
               lifo_we = 1'b1;
               if (step_q == SelZ) begin
                  sp_d    = sp_full ? sp_q : sp_q + SpOne;
                  step_d  = SelA;
                  state_d = StFin;
               end else begin
                  step_d = step_q - 2'd1;
               end
            end
         end
         // Step is kept so an interrupted restore resumes where it stopped.
         StRstWait: begin
            if (map_idle_i) begin
               state_d = StRestore;
            end
         end
         StRestore: begin
            if (!map_idle_i) begin
               state_d = StRstWait;
            end else if (step_q == SelZ) begin
               sp_d    = sp_empty ? sp_q : sp_q - SpOne;
               step_d  = SelA;
               state_d = StFin;
            end else begin
               step_d = step_q - 2'd1;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from the current state.
   always_comb begin
      rd_override_o   = (state_q == StSave);
      rd_sel_o        = step_q;
      load_user_reg_o = (state_q == StRestore) && map_idle_i;
      wr_sel_o        = step_q;
      wr_data_o       = (state_q == StRestore) ? lifo_rd : 8'h00;
      busy_o          = (state_q != StIdle);
      done_o          = (state_q == StFin) || err_done_q;
      err_o           = err_q;
      depth_o         = sp_q;
   end

   mapper_ctx_lifo #(
      .DEPTH(DEPTH),
      .PW   (PW)
   ) u_lifo (
      .clk_i    (clk_i),
      .we_i     (lifo_we),
      .wr_slot_i(sp_q[PW-1:0]),
      .wr_byte_i(step_q),
      .wr_data_i(map_reg_data_i),
      .rd_slot_i(sp_q[PW-1:0] - PW'(1)),
      .rd_byte_i(step_q),
      .rd_data_o(lifo_rd)
   );

endmodule
